// File: rtl/data_bank_pkg.sv
// data_bank_pkg: shared types and helpers for the data bank selector.
//   state_e  : read-out FSM state (IDLE, BURST)
//   next_adr : successor address with explicit wrap from depth-1 to 0,
//              so non-power-of-two depths never visit unused addresses.
package data_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic int unsigned next_adr(input int unsigned adr,
                                             input int unsigned depth);
        return (adr == depth - 1) ? 0 : adr + 1;
    endfunction

endpackage

// File: rtl/bank_scan_counter.sv
// bank_scan_counter: burst address generator for the data bank selector.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : burst start; first beat is emitted by the top this edge
//   start_adr_i   : address of the first beat
//   advance_i     : one further burst beat is emitted this edge
//   adr_o         : address of the next beat to emit
//   last_o        : the next beat to emit is the final one of the burst
module bank_scan_counter
    import data_bank_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ADR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [ADR_W-1:0] start_adr_i,
    input  logic             advance_i,
    output logic [ADR_W-1:0] adr_o,
    output logic             last_o
);

    // Counts beats already emitted; wide enough to reach DEPTH.
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADR_W-1:0] adr_q, adr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        adr_d = adr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            // The load edge already emits the start cell, so point past it.
            adr_d = ADR_W'(next_adr(32'(start_adr_i), DEPTH));
            cnt_d = CNT_W'(1);
        end else if (advance_i) begin
            adr_d = ADR_W'(next_adr(32'(adr_q), DEPTH));
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign adr_o  = adr_q;
    assign last_o = (cnt_q == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/data_bank_selector.sv
// data_bank_selector: DEPTH x DATA_W register bank with addressed store,
// single read-out and auto-incrementing burst read-out.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   data_i        : data to store
//   adr_i         : address for store, single read or burst start
//   read_sig_i    : store data_i into cell[adr_i]
//   write_sig_i   : single read-out of cell[adr_i]
//   burst_i       : burst read-out of all cells starting at cell[adr_i]
//   data_o        : registered read-out data (holds between beats)
//   valid_o       : data_o carries a beat
//   last_o        : final beat of a burst
//   busy_o        : burst in progress, read-out requests dropped
module data_bank_selector
    import data_bank_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic              read_sig_i,
    input  logic              write_sig_i,
    input  logic              burst_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, last_q, busy_q;

    logic              adr_ok;
    logic              start_burst;
    logic              advance;
    logic [ADR_W-1:0]  scan_adr;
    logic              scan_last;

    assign adr_ok      = (32'(adr_i) < DEPTH);
    assign start_burst = (state_q == IDLE) && burst_i && adr_ok;
    // Advance only while beats remain; the cycle after the last beat is
    // still BURST so requests arriving during the last beat are dropped.
    assign advance     = (state_q == BURST) && !last_q;

    bank_scan_counter #(
        .DEPTH (DEPTH),
        .ADR_W (ADR_W)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (start_burst),
        .start_adr_i (adr_i),
        .advance_i   (advance),
        .adr_o       (scan_adr),
        .last_o      (scan_last)
    );

    // Storage: reads below see the pre-edge contents (read-before-write).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (read_sig_i && adr_ok) begin
            mem_q[adr_i] <= data_i;
        end
    end

    // Read-out FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (burst_i && adr_ok) begin
                        state_q <= BURST;
                        data_q  <= mem_q[adr_i];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (write_sig_i && adr_ok) begin
                        data_q  <= mem_q[adr_i];
                        valid_q <= 1'b1;
                    end
                end
                BURST: begin
                    if (last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q  <= mem_q[scan_adr];
                        valid_q <= 1'b1;
                        last_q  <= scan_last;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_data_bank_selector.sv
module tb_data_bank_selector;

    logic       clk;
    logic       rst_n;
    // DEPTH=4 instance
    logic [7:0] dat4, dout4;
    logic [1:0] adr4;
    logic       rd4, wr4, bu4, v4, l4, b4;
    // DEPTH=5 instance
    logic [7:0] dat5, dout5;
    logic [2:0] adr5;
    logic       rd5, wr5, bu5, v5, l5, b5;

    int pass_cnt = 0;
    int total_cnt = 0;

    data_bank_selector #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat4), .adr_i(adr4),
        .read_sig_i(rd4), .write_sig_i(wr4), .burst_i(bu4),
        .data_o(dout4), .valid_o(v4), .last_o(l4), .busy_o(b4));

    data_bank_selector #(.DATA_W(8), .DEPTH(5)) u_d5 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(dat5), .adr_i(adr5),
        .read_sig_i(rd5), .write_sig_i(wr5), .burst_i(bu5),
        .data_o(dout5), .valid_o(v5), .last_o(l5), .busy_o(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // Per instance: cell contents, expected outputs, and the remaining
    // burst beats. A burst is tracked as "beats left" plus a read pointer.
    int mem_m [2][5];
    int ed [2], ev [2], el [2], eb [2];
    int left [2], badr [2], bidx [2];
    bit armed [2];

    task automatic model_step(input int d, input int depth, input int rst,
                              input int rd, input int wr, input int bu,
                              input int adr, input int dat);
        if (rst == 0) begin
            for (int i = 0; i < 5; i++) mem_m[d][i] = 0;
            ed[d] = 0; ev[d] = 0; el[d] = 0; eb[d] = 0; left[d] = 0;
            armed[d] = 1'b1;
            return;
        end
        ev[d] = 0;
        el[d] = 0;
        if (left[d] > 0) begin
            ed[d]   = mem_m[d][badr[d]];
            ev[d]   = 1;
            bidx[d] = bidx[d] + 1;
            el[d]   = (bidx[d] == depth) ? 1 : 0;
            badr[d] = (badr[d] + 1) % depth;
            left[d] = left[d] - 1;
            eb[d]   = 1;
        end else if (eb[d] != 0) begin
            eb[d] = 0;                    // last-beat cycle: requests dropped
        end else if (bu != 0 && adr < depth) begin
            ed[d]   = mem_m[d][adr];
            ev[d]   = 1;
            eb[d]   = 1;
            bidx[d] = 1;
            badr[d] = (adr + 1) % depth;
            left[d] = depth - 1;
        end else if (wr != 0 && adr < depth) begin
            ed[d] = mem_m[d][adr];
            ev[d] = 1;
        end
        if (rd != 0 && adr < depth) mem_m[d][adr] = dat;
    endtask

    always @(posedge clk) begin
        model_step(0, 4, int'(rst_n), int'(rd4), int'(wr4), int'(bu4), int'(adr4), int'(dat4));
        model_step(1, 5, int'(rst_n), int'(rd5), int'(wr5), int'(bu5), int'(adr5), int'(dat5));
    end

    // ---------------- compare + beat capture ----------------
    int cap [2][64];
    int cap_last [2][64];
    int ncap [2];
    int nbusy [2];

    always @(negedge clk) begin
        if (armed[0]) begin
            chk("d4_data",  int'(dout4), ed[0]);
            chk("d4_valid", int'(v4),    ev[0]);
            chk("d4_last",  int'(l4),    el[0]);
            chk("d4_busy",  int'(b4),    eb[0]);
        end
        if (armed[1]) begin
            chk("d5_data",  int'(dout5), ed[1]);
            chk("d5_valid", int'(v5),    ev[1]);
            chk("d5_last",  int'(l5),    el[1]);
            chk("d5_busy",  int'(b5),    eb[1]);
        end
        if (v4 && ncap[0] < 64) begin
            cap[0][ncap[0]] = int'(dout4); cap_last[0][ncap[0]] = int'(l4); ncap[0]++;
        end
        if (v5 && ncap[1] < 64) begin
            cap[1][ncap[1]] = int'(dout5); cap_last[1][ncap[1]] = int'(l5); ncap[1]++;
        end
        if (b4) nbusy[0]++;
        if (b5) nbusy[1]++;
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        ncap[0] = 0; ncap[1] = 0; nbusy[0] = 0; nbusy[1] = 0;
    endtask

    // Literal pins on captured beats: count, values, and last-flag index.
    task automatic chk_beats(input string nm, input int d, input int n,
                             input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int last_idx);
        int e [5];
        int li;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        chk({nm, "_count"}, ncap[d], n);
        li = -1;
        for (int i = 0; i < ncap[d] && i < 5; i++) begin
            if (i < n) chk({nm, "_beat"}, cap[d][i], e[i]);
            if (cap_last[d][i] != 0 && li < 0) li = i;
        end
        chk({nm, "_last_idx"}, li, last_idx);
    endtask

    task automatic idle_inputs();
        rd4 = 0; wr4 = 0; bu4 = 0; adr4 = '0; dat4 = '0;
        rd5 = 0; wr5 = 0; bu5 = 0; adr5 = '0; dat5 = '0;
    endtask

    initial begin
        ncap[0] = 0; ncap[1] = 0; nbusy[0] = 0; nbusy[1] = 0;
        armed[0] = 1'b0; armed[1] = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        cyc(2);
        chk("rst_valid", int'(v4), 0);
        chk("rst_busy",  int'(b4), 0);
        rst_n = 1'b1;

        // Store 64/32/2/1 into D4 cells 0..3.
        rd4 = 1;
        adr4 = 2'd0; dat4 = 8'd64; cyc();
        adr4 = 2'd1; dat4 = 8'd32; cyc();
        adr4 = 2'd2; dat4 = 8'd2;  cyc();
        adr4 = 2'd3; dat4 = 8'd1;  cyc();
        rd4 = 0;

        // Held single read at adr 1.
        clr();
        wr4 = 1; adr4 = 2'd1; cyc(3); wr4 = 0; cyc(2);
        chk_beats("single_hold", 0, 3, 32, 32, 32, 0, 0, -1);

        // Burst from adr 2.
        clr();
        bu4 = 1; adr4 = 2'd2; cyc(); bu4 = 0; cyc(5);
        chk_beats("burst2", 0, 4, 2, 1, 64, 32, 0, 3);
        chk("burst2_busy_cycles", nbusy[0], 4);

        // Mid-burst stores: cell 3 ahead of the pointer, cell 2 at the same edge.
        clr();
        bu4 = 1; adr4 = 2'd0; cyc(); bu4 = 0;
        rd4 = 1; adr4 = 2'd3; dat4 = 8'd99; cyc();
        adr4 = 2'd2; dat4 = 8'd77; cyc();
        rd4 = 0; cyc(3);
        chk_beats("midstore", 0, 4, 64, 32, 2, 99, 0, 3);
        clr();
        wr4 = 1; adr4 = 2'd2; cyc(); wr4 = 0; cyc();
        chk_beats("rbw_after", 0, 1, 77, 0, 0, 0, 0, -1);

        // Requests during busy (including the last-beat cycle) are dropped.
        clr();
        bu4 = 1; adr4 = 2'd1; cyc();
        wr4 = 1; bu4 = 1; adr4 = 2'd0; cyc(4);
        wr4 = 0; bu4 = 0; cyc(2);
        chk_beats("busy_drop", 0, 4, 32, 77, 99, 64, 0, 3);

        // Simultaneous write_sig + burst in IDLE: burst wins.
        clr();
        wr4 = 1; bu4 = 1; adr4 = 2'd3; cyc(); wr4 = 0; bu4 = 0; cyc(5);
        chk_beats("prio", 0, 4, 99, 64, 32, 77, 0, 3);

        // Reset after beat 2 aborts the burst and clears everything.
        clr();
        bu4 = 1; adr4 = 2'd0; cyc(); bu4 = 0; cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("abort_valid", int'(v4), 0);
        chk("abort_busy",  int'(b4), 0);
        chk("abort_data",  int'(dout4), 0);
        cyc(6);
        chk_beats("abort", 0, 2, 64, 32, 0, 0, 0, -1);
        clr();
        bu4 = 1; adr4 = 2'd0; cyc(); bu4 = 0; cyc(5);
        chk_beats("cleared", 0, 4, 0, 0, 0, 0, 0, 3);

        // DEPTH=5: wrap 4 -> 0, out-of-range store/read/burst ignored.
        rd5 = 1;
        for (int i = 0; i < 5; i++) begin
            adr5 = 3'(i); dat5 = 8'(10 + i); cyc();
        end
        adr5 = 3'd6; dat5 = 8'd170; cyc();
        rd5 = 0;
        clr();
        bu5 = 1; adr5 = 3'd4; cyc(); bu5 = 0; cyc(6);
        chk_beats("d5_wrap", 1, 5, 14, 10, 11, 12, 13, 4);
        chk("d5_busy_cycles", nbusy[1], 5);
        clr();
        wr5 = 1; adr5 = 3'd6; cyc(); wr5 = 0;
        bu5 = 1; adr5 = 3'd5; cyc(); bu5 = 0; cyc(3);
        chk("d5_oor_beats", ncap[1], 0);

        // Randomized phase, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            rd4 = ($urandom_range(0, 2) == 0); wr4 = ($urandom_range(0, 2) == 0);
            bu4 = ($urandom_range(0, 9) == 0); adr4 = 2'($urandom_range(0, 3));
            dat4 = 8'($urandom_range(0, 255));
            rd5 = ($urandom_range(0, 2) == 0); wr5 = ($urandom_range(0, 2) == 0);
            bu5 = ($urandom_range(0, 9) == 0); adr5 = 3'($urandom_range(0, 7));
            dat5 = 8'($urandom_range(0, 255));
            cyc();
        end
        idle_inputs();
        rst_n = 1'b1;
        cyc(8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
